rf_alu_sequencer: RTL and testbench

//  Sequences two-operand ALU ops over the 8-entry register file (1 read port, 1 write port).

---
 rtl/rf_alu_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_rf_alu_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_alu_sequencer.sv
// ---------------------------------------------------------------------------
// rf_alu_sequencer
//
// Runs one two-operand ALU command at a time against a register file that
// has a single combinational read port and a single write port. A command
// (op, rd, rs1, rs2) is accepted in IDLE. Operand A is read in RD_A and
// operand B in RD_B. The result is written back to rd in WB. DONE then
// raises a one-cycle completion pulse. Both reads always finish before the
// write, so any overlap between rd and the source registers reads the old
// values.
//
// Ports
//   clk, reset      clock; asynchronous active-high reset
//   cmd_valid/ready command handshake; accepted on valid & ready at posedge
//   cmd_op          00 ADD, 01 SUB (rs1-rs2), 10 AND, 11 XOR
//   cmd_rd/rs1/rs2  destination and source register indices
//   rf_read_sel     register-file read select (zero outside RD_A/RD_B)
//   rf_data_out     register-file read data (combinational)
//   rf_write_sel    register-file write select (zero outside WB)
//   rf_write_en     register-file write enable (WB only)
//   rf_data_in      register-file write data (zero outside WB)
//   busy            high whenever the sequencer is not in IDLE
//   done            one-cycle pulse after the write-back
//   result          last written-back value, held until the next write-back
//   flag_c          ADD carry-out / SUB borrow; 0 for AND and XOR
//   flag_z          last written-back value was zero
// ---------------------------------------------------------------------------
module rf_alu_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    output logic [ADDR_W-1:0] rf_read_sel,
    input  logic [DATA_W-1:0] rf_data_out,
    output logic [ADDR_W-1:0] rf_write_sel,
    output logic              rf_write_en,
    output logic [DATA_W-1:0] rf_data_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              flag_c,
    output logic              flag_z
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_WB,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_t;

    state_t state;
    state_t state_nxt;

    // Command fields latched at the accept edge. Input changes while the
    // sequencer is busy are ignored.
    op_t               op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;

    // Operands captured from the read port.
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;

    // One extra bit holds the ADD carry. For SUB it holds the borrow: the
    // (DATA_W+1)-bit difference of zero-extended operands has its top bit
    // set exactly when a_q < b_q.
    logic [DATA_W:0]   alu_wide;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;

    logic              accept;

    assign accept = (state == S_IDLE) && cmd_valid;

    // ------------------------------------------------------------------
    // ALU, purely combinational from the operand registers
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no
        // path leaves it unassigned, which would infer a latch.
        alu_wide = '0;
        case (op_q)
            OP_ADD:  alu_wide = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB:  alu_wide = {1'b0, a_q} - {1'b0, b_q};
            OP_AND:  alu_wide = {1'b0, a_q & b_q};
            default: alu_wide = {1'b0, a_q ^ b_q};
        endcase
    end

    assign alu_res = alu_wide[DATA_W-1:0];
    assign alu_c   = alu_wide[DATA_W];

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        cmd_ready    = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        rf_read_sel  = '0;
        rf_write_sel = '0;
        rf_write_en  = 1'b0;
        rf_data_in   = '0;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                // Ready is held low while reset is high. It rises in the
                // first cycle after reset is released.
                cmd_ready = ~reset;
                if (cmd_valid) begin
                    state_nxt = S_RD_A;
                end
            end
            S_RD_A: begin
                rf_read_sel = rs1_q;
                state_nxt   = S_RD_B;
            end
            S_RD_B: begin
                rf_read_sel = rs2_q;
                state_nxt   = S_WB;
            end
            S_WB: begin
                // The write enable decodes directly from the state register.
                // An asynchronous reset therefore cancels the write at once.
                rf_write_en  = 1'b1;
                rf_write_sel = rd_q;
                rf_data_in   = alu_res;
                state_nxt    = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, command latch, operands and results
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: every register here has a defined reset value. The
            // register file itself sits outside this block and keeps its
            // contents through reset.
            state  <= S_IDLE;
            op_q   <= OP_ADD;
            rd_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so all
            // registers update together from values read before the edge.
            state <= state_nxt;

            if (accept) begin
                op_q  <= op_t'(cmd_op);
                rd_q  <= cmd_rd;
                rs1_q <= cmd_rs1;
                rs2_q <= cmd_rs2;
            end

            if (state == S_RD_A) begin
                a_q <= rf_data_out;
            end

            if (state == S_RD_B) begin
                b_q <= rf_data_out;
            end

            if (state == S_WB) begin
                result <= alu_res;
                flag_c <= alu_c;
                flag_z <= (alu_res == '0);
            end
        end
    end

endmodule

// File: tb/tb_rf_alu_sequencer.sv
module tb_rf_alu_sequencer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 1 << ADDR_W;
    localparam int MODV   = 1 << DATA_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = '0;
    logic [ADDR_W-1:0] cmd_rd = '0;
    logic [ADDR_W-1:0] cmd_rs1 = '0;
    logic [ADDR_W-1:0] cmd_rs2 = '0;
    logic [ADDR_W-1:0] rf_read_sel;
    logic [DATA_W-1:0] rf_data_out;
    logic [ADDR_W-1:0] rf_write_sel;
    logic              rf_write_en;
    logic [DATA_W-1:0] rf_data_in;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              flag_c;
    logic              flag_z;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_alu_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_rd       (cmd_rd),
        .cmd_rs1      (cmd_rs1),
        .cmd_rs2      (cmd_rs2),
        .rf_read_sel  (rf_read_sel),
        .rf_data_out  (rf_data_out),
        .rf_write_sel (rf_write_sel),
        .rf_write_en  (rf_write_en),
        .rf_data_in   (rf_data_in),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .flag_c       (flag_c),
        .flag_z       (flag_z)
    );

    // Register file: combinational read, write on posedge. The bench preloads
    // values through its own side port while the sequencer is idle.
    logic [DATA_W-1:0] rf_mem [NREGS];
    logic              tb_we = 1'b0;
    logic [ADDR_W-1:0] tb_sel = '0;
    logic [DATA_W-1:0] tb_din = '0;

    assign rf_data_out = rf_mem[rf_read_sel];

    always @(posedge clk) begin
        if (rf_write_en) rf_mem[rf_write_sel] <= rf_data_in;
        else if (tb_we)  rf_mem[tb_sel]       <= tb_din;
    end

    // Reference model: the expected register file contents.
    int model_rf [NREGS];

    function automatic void alu_model(input int op, input int a, input int b,
                                      output int r, output int c);
        case (op)
            0: begin r = (a + b) % MODV;        c = ((a + b) >= MODV) ? 1 : 0; end
            1: begin r = (a - b + MODV) % MODV; c = (a < b) ? 1 : 0;           end
            2: begin r = a & b;                 c = 0;                         end
            default: begin r = a ^ b;           c = 0;                         end
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_reg(input int idx, input int val);
        @(negedge clk);
        tb_we  = 1'b1;
        tb_sel = idx[ADDR_W-1:0];
        tb_din = val[DATA_W-1:0];
        model_rf[idx] = val;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // Issue one command and follow it to completion. With scramble set, the
    // command inputs are changed randomly while the sequencer is busy.
    task automatic run_cmd(input int op, input int rd, input int rs1, input int rs2,
                           input bit scramble, input string tag);
        int exp_r, exp_c, done_cyc, we_cnt, hs_err;
        alu_model(op, model_rf[rs1], model_rf[rs2], exp_r, exp_c);
        @(negedge clk);
        check({tag, ":ready_idle"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op[1:0];
        cmd_rd    = rd[ADDR_W-1:0];
        cmd_rs1   = rs1[ADDR_W-1:0];
        cmd_rs2   = rs2[ADDR_W-1:0];
        @(posedge clk);
        done_cyc = 0; we_cnt = 0; hs_err = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (scramble) begin
                cmd_op  = 2'($urandom);
                cmd_rd  = ADDR_W'($urandom);
                cmd_rs1 = ADDR_W'($urandom);
                cmd_rs2 = ADDR_W'($urandom);
            end
            if (rf_write_en) we_cnt++;
            if (!busy || cmd_ready) hs_err++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        model_rf[rd] = exp_r;
        check({tag, ":latency"}, done_cyc, 4);
        check({tag, ":we_cycles"}, we_cnt, 1);
        check({tag, ":busy_ready"}, hs_err, 0);
        check({tag, ":result"}, result, exp_r);
        check({tag, ":flag_c"}, flag_c, exp_c);
        check({tag, ":flag_z"}, flag_z, (exp_r == 0) ? 1 : 0);
        check({tag, ":rf_rd"}, rf_mem[rd], exp_r);
        @(negedge clk);
        check({tag, ":done_pulse"}, {busy, done, cmd_ready}, 3'b001);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp1, c1, exp2, c2, acc, dn, hs, first_acc, second_acc, keep7;

        // ---------------- reset state ----------------
        @(negedge clk);
        check("rst:ready", cmd_ready, 0);
        check("rst:busy_done_we", {busy, done, rf_write_en}, 3'b000);
        check("rst:result", result, 0);
        check("rst:flags", {flag_c, flag_z}, 2'b00);
        check("rst:selects", {rf_read_sel, rf_write_sel}, 0);
        reset = 1'b0;
        #1 check("rst:ready_after_release", cmd_ready, 1);

        for (int i = 0; i < NREGS; i++) set_reg(i, $urandom_range(0, MODV - 1));

        // ---------------- directed cases ----------------
        set_reg(1, 8'h30); set_reg(2, 8'h12);
        run_cmd(0, 3, 1, 2, 1'b0, "t1_add");
        check("t1_value", rf_mem[3], 8'h42);

        set_reg(1, 8'hF0); set_reg(2, 8'h20);
        run_cmd(0, 4, 1, 2, 1'b0, "t2_add_carry");
        check("t2_add_value", {flag_c, rf_mem[4]}, 9'h110);
        run_cmd(1, 5, 2, 1, 1'b0, "t2_sub_borrow");
        check("t2_sub_value", {flag_c, rf_mem[5]}, 9'h130);

        set_reg(6, 8'h5A);
        run_cmd(3, 6, 6, 6, 1'b0, "t3_xor_self");
        check("t3_value", {flag_z, rf_mem[6]}, 9'h100);

        // rd overlapping a source register reads the old value.
        run_cmd(2, 1, 1, 4, 1'b0, "and_rd_eq_rs1");

        // ---------------- back-to-back with cmd_valid held ----------------
        alu_model(0, model_rf[1], model_rf[2], exp1, c1);
        model_rf[0] = exp1;
        alu_model(3, model_rf[0], model_rf[3], exp2, c2);
        model_rf[1] = exp2;
        acc = 0; dn = 0; hs = 0; first_acc = -1; second_acc = -1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_rd = 3'd0; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (cmd_valid && cmd_ready) begin
                if (acc == 0) first_acc = cyc; else second_acc = cyc;
                acc++;
            end
            @(negedge clk);
            if (acc == 1 && first_acc == cyc) begin
                cmd_op = 2'd3; cmd_rd = 3'd1; cmd_rs1 = 3'd0; cmd_rs2 = 3'd3;
            end
            if (acc == 2 && second_acc == cyc) cmd_valid = 1'b0;
            if (done) dn++;
            if (busy == cmd_ready) hs++;
        end
        check("b2b:accepts", acc, 2);
        check("b2b:gap", second_acc - first_acc, 5);
        check("b2b:dones", dn, 2);
        check("b2b:ready_vs_busy", hs, 0);
        check("b2b:r0", rf_mem[0], exp1);
        check("b2b:r1", rf_mem[1], exp2);
        check("b2b:result", result, exp2);

        // ---------------- reset during RD_B ----------------
        keep7 = model_rf[7];
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_rd = 3'd7; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2;
        @(negedge clk); cmd_valid = 1'b0;      // RD_A
        @(negedge clk);                         // RD_B
        #2 reset = 1'b1;
        #1;
        check("rstB:outputs", {busy, done, rf_write_en, cmd_ready}, 4'b0000);
        check("rstB:result_flags", {result, flag_c, flag_z}, 0);
        @(negedge clk); reset = 1'b0;
        #1 check("rstB:ready", cmd_ready, 1);
        check("rstB:r7_kept", rf_mem[7], keep7);

        // ---------------- reset during WB ----------------
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_rd = 3'd7; cmd_rs1 = 3'd3; cmd_rs2 = 3'd4;
        @(negedge clk); cmd_valid = 1'b0;      // RD_A
        @(negedge clk);                         // RD_B
        @(negedge clk);                         // WB
        check("rstW:we_before", rf_write_en, 1);
        #2 reset = 1'b1;
        #1;
        check("rstW:outputs", {busy, done, rf_write_en, cmd_ready}, 4'b0000);
        check("rstW:result_flags", {result, flag_c, flag_z}, 0);
        @(negedge clk); reset = 1'b0;
        #1 check("rstW:ready", cmd_ready, 1);
        check("rstW:r7_kept", rf_mem[7], keep7);
        run_cmd(0, 7, 3, 4, 1'b0, "post_reset_add");

        // ---------------- inputs changing while busy ----------------
        run_cmd(1, 2, 5, 6, 1'b1, "t6_scramble_sub");
        run_cmd(3, 5, 0, 7, 1'b1, "t6_scramble_xor");

        // ---------------- random commands ----------------
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0)
                set_reg($urandom_range(0, NREGS - 1), $urandom_range(0, MODV - 1));
            run_cmd($urandom_range(0, 3), $urandom_range(0, NREGS - 1),
                    $urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1),
                    1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
